// File: rtl/dmem_wait.sv
// dmem_wait: word-organised data memory with req/ready/rvalid handshake,
// WAIT programmable wait states, byte-lane write strobes and error flagging.
// Optional per-lane even parity is enabled by defining DMEM_PARITY_EN.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   req    - access request; accepted when ready = 1
//   we     - 1 = write, 0 = read (sampled on accept)
//   be     - byte-lane write enables (sampled on accept)
//   a      - byte address (sampled on accept)
//   wd     - write data (sampled on accept)
//   pinj   - parity inject: inverts the stored parity of written lanes
//   ready  - block is idle and can accept a request
//   rvalid - one-cycle response strobe
//   rd     - read data, qualified by rvalid
//   err    - misaligned or out-of-range access, qualified by rvalid
//   perr   - parity mismatch on a read, qualified by rvalid
module dmem_wait #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WAIT   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DATA_W-1:0]   wd,
  input  logic                pinj,
  output logic                ready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rd,
  output logic                err,
  output logic                perr
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAITS = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            cap_we_q;
  logic            cap_err_q;
  logic [NB-1:0]   cap_be_q;
  logic [IW-1:0]   cap_idx_q;
  logic [DATA_W-1:0] cap_wd_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic            accept_c;
  logic            in_err_c;
  logic [IW-1:0]   in_idx_c;
  logic            cur_we_c;
  logic            cur_err_c;
  logic [IW-1:0]   cur_idx_c;
  logic [DATA_W-1:0] rdata_c;
  logic            par_bad_c;

  logic            rvalid_d;
  logic [DATA_W-1:0] rd_d;
  logic            err_d;
  logic            perr_d;

  // Request decode; the address upper bits decide the range check so that
  // out-of-range accesses never alias onto low words.
  assign accept_c = (state_q == S_IDLE) && req;
  assign in_idx_c = a[2+IW-1:2];
  assign in_err_c = (a[1:0] != 2'b00) || ((a >> 2) >= ADDR_W'(DEPTH));

  // The response is prepared on the edge that enters RESP; with WAIT = 0
  // that edge is the accept edge itself, so use the live inputs then.
  assign cur_we_c  = (state_q == S_IDLE) ? we       : cap_we_q;
  assign cur_err_c = (state_q == S_IDLE) ? in_err_c : cap_err_q;
  assign cur_idx_c = (state_q == S_IDLE) ? in_idx_c : cap_idx_q;
  assign rdata_c   = mem_q[cur_idx_c];

  // Next-state and response logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    rd_d     = '0;
    err_d    = 1'b0;
    perr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = '0;
          state_d = (WAIT == 0) ? S_RESP : S_WAITS;
        end
      end
      S_WAITS: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WAIT - 1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_RESP) begin
      rvalid_d = 1'b1;
      err_d    = cur_err_c;
      if (!cur_err_c && !cur_we_c) begin
        rd_d   = rdata_c;
        perr_d = par_bad_c;
      end
    end
  end

  // State, counter, request capture and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cap_we_q  <= 1'b0;
      cap_err_q <= 1'b0;
      cap_be_q  <= '0;
      cap_idx_q <= '0;
      cap_wd_q  <= '0;
      ready     <= 1'b1;
      rvalid    <= 1'b0;
      rd        <= '0;
      err       <= 1'b0;
      perr      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_c) begin
        cap_we_q  <= we;
        cap_err_q <= in_err_c;
        cap_be_q  <= be;
        cap_idx_q <= in_idx_c;
        cap_wd_q  <= wd;
      end
      ready  <= (state_d == S_IDLE);
      rvalid <= rvalid_d;
      rd     <= rd_d;
      err    <= err_d;
      perr   <= perr_d;
    end
  end

  // Array write commits only on the edge leaving RESP; a reset clears the
  // state first, so an aborted access never reaches this point.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && cap_we_q && !cap_err_q) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (cap_be_q[i]) begin
          mem_q[cap_idx_q][8*i +: 8] <= cap_wd_q[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic          cap_pinj_q;
  logic [NB-1:0] par_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_pinj_q <= 1'b0;
    end else if (accept_c) begin
      cap_pinj_q <= pinj;
    end
  end

  // Even parity per lane, optionally inverted by the inject hook.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && cap_we_q && !cap_err_q) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (cap_be_q[i]) begin
          par_q[cur_idx_c][i] <= (^cap_wd_q[8*i +: 8]) ^ cap_pinj_q;
        end
      end
    end
  end

  always_comb begin
    par_bad_c = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((^rdata_c[8*i +: 8]) != par_q[cur_idx_c][i]) begin
        par_bad_c = 1'b1;
      end
    end
  end
`else
  logic unused_pinj;
  assign unused_pinj = pinj;
  assign par_bad_c   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_wait.sv
// Self-checking bench for dmem_wait: directed vector table, WAIT=0
// back-to-back, reset abort, parity inject and randomized accesses checked
// against a behavioural memory model.
module tb_dmem_wait;

  logic        clk;
  logic        reset;
  logic        req2, req0;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a;
  logic [31:0] wd;
  logic        pinj;

  logic        ready2, rvalid2, err2, perr2;
  logic [31:0] rd2;
  logic        ready0, rvalid0, err0, perr0;
  logic [31:0] rd0;

  int n_chk;
  int n_fail;

  // Behavioural model: word contents and "lane parity was inverted" flags.
  logic [31:0] mm   [64];
  logic [3:0]  pbad [64];

  dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .be(be), .a(a), .wd(wd),
    .pinj(pinj), .ready(ready2), .rvalid(rvalid2), .rd(rd2), .err(err2),
    .perr(perr2)
  );

  dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .be(be), .a(a), .wd(wd),
    .pinj(pinj), .ready(ready0), .rvalid(rvalid0), .rd(rd0), .err(err0),
    .perr(perr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference rules: error on misalignment or word index >= 64; strobed
  // lane merge on writes; read returns the word, perr if any lane was injected.
  task automatic model_apply(input logic w, input logic [3:0] b, input logic [31:0] ad,
                             input logic [31:0] d, input logic pi,
                             output logic [31:0] erd, output logic eerr, output logic eperr);
    int unsigned idx;
    idx   = int'(ad[7:2]);
    eerr  = (ad[1:0] != 2'b00) || ((ad >> 2) >= 32'd64);
    erd   = '0;
    eperr = 1'b0;
    if (!eerr) begin
      if (w) begin
        for (int l = 0; l < 4; l++) begin
          if (b[l]) begin
            mm[idx][8*l +: 8] = d[8*l +: 8];
            pbad[idx][l]      = pi;
          end
        end
      end else begin
        erd = mm[idx];
`ifdef DMEM_PARITY_EN
        eperr = |pbad[idx];
`endif
      end
    end
  endtask

  // One access on the WAIT=2 instance; starts and ends at a falling edge.
  task automatic acc2(input logic w, input logic [3:0] b, input logic [31:0] ad,
                      input logic [31:0] d, input logic pi,
                      output logic [31:0] ord, output logic oerr, output logic operr);
    int n;
    int lat;
    we = w; be = b; a = ad; wd = d; pinj = pi; req2 = 1'b1;
    n = 0;
    while (!ready2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 32'(ready2), 32'd1);
    @(posedge clk);
    #1;
    req2 = 1'b0;
    we = 1'($urandom); be = 4'($urandom); a = $urandom; wd = $urandom; pinj = 1'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rvalid2 && lat < 40) chk("ready_low_busy", 32'(ready2), 32'd0);
    end while (!rvalid2 && lat < 40);
    chk("latency", 32'(lat), 32'd3);
    ord = rd2; oerr = err2; operr = perr2;
    @(negedge clk);
    chk("rvalid_one_cycle", 32'(rvalid2), 32'd0);
    chk("idle_rd_zero", rd2, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  b;
    logic [31:0] ad;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] grd, erd;
    logic        gerr, gperr, eerr, eperr;
    n_chk = 0; n_fail = 0;
    reset = 1'b0; req2 = 0; req0 = 0; we = 0; be = 0; a = 0; wd = 0; pinj = 0;
    for (int i = 0; i < 64; i++) begin mm[i] = '0; pbad[i] = '0; end

    vt[0]  = '{1'b1, 4'hF, 32'h8,   32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 4'h0, 32'h8,   32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 4'h5, 32'h8,   32'h11223344, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 4'hF, 32'h8,   32'h0,        32'hDE22BE44, 1'b0};
    vt[4]  = '{1'b0, 4'h0, 32'h6,   32'h0,        32'h0,        1'b1};
    vt[5]  = '{1'b0, 4'h0, 32'h100, 32'h0,        32'h0,        1'b1};
    vt[6]  = '{1'b1, 4'hF, 32'h100, 32'hFFFFFFFF, 32'h0,        1'b1};
    vt[7]  = '{1'b1, 4'hF, 32'h2,   32'hFFFFFFFF, 32'h0,        1'b1};
    vt[8]  = '{1'b0, 4'h0, 32'h0,   32'h0,        32'hA5A50000, 1'b0};
    vt[9]  = '{1'b1, 4'h0, 32'h8,   32'h99999999, 32'h0,        1'b0};
    vt[10] = '{1'b0, 4'h0, 32'h8,   32'h0,        32'hDE22BE44, 1'b0};
    vt[11] = '{1'b0, 4'h0, 32'hFC,  32'h0,        32'hA5A50000 ^ (32'd63 * 32'h01010103), 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready2), 32'd1);
    chk("rst_rvalid", 32'(rvalid2), 32'd0);
    chk("rst_rd", rd2, 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    chk("rst_perr", 32'(perr2), 32'd0);
    chk("rst_ready0", 32'(ready0), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // Fill every word with a known pattern.
    for (int i = 0; i < 64; i++) begin
      wd = 32'hA5A50000 ^ (32'(i) * 32'h01010103);
      model_apply(1'b1, 4'hF, 32'(i) << 2, wd, 1'b0, erd, eerr, eperr);
      acc2(1'b1, 4'hF, 32'(i) << 2, 32'hA5A50000 ^ (32'(i) * 32'h01010103), 1'b0, grd, gerr, gperr);
      chk("init_err", 32'(gerr), 32'd0);
    end

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      model_apply(vt[i].w, vt[i].b, vt[i].ad, vt[i].d, 1'b0, erd, eerr, eperr);
      acc2(vt[i].w, vt[i].b, vt[i].ad, vt[i].d, 1'b0, grd, gerr, gperr);
      chk($sformatf("vec%0d_rd", i), grd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(gerr), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_perr", i), 32'(gperr), 32'd0);
    end

    // WAIT=0: one write, then back-to-back reads with req held high.
    we = 1'b1; be = 4'hF; a = 32'h4; wd = 32'hCAFEF00D; pinj = 1'b0; req0 = 1'b1;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    chk("w0_write_rvalid", 32'(rvalid0), 32'd1);
    chk("w0_write_err", 32'(err0), 32'd0);
    @(negedge clk);
    we = 1'b0; req0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("w0_rvalid_k%0d", k), 32'(rvalid0), 32'(k % 2));
      chk($sformatf("w0_ready_k%0d", k), 32'(ready0), 32'((k + 1) % 2));
      chk($sformatf("w0_rd_k%0d", k), rd0, (k % 2 == 1) ? 32'hCAFEF00D : 32'h0);
    end
    req0 = 1'b0;
    @(negedge clk);

    // Reset during the wait states aborts the pending write.
    we = 1'b1; be = 4'hF; a = 32'h8; wd = 32'h55555555; req2 = 1'b1;
    @(posedge clk);
    #1 req2 = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(ready2), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(ready2), 32'd1);
    chk("abort_rvalid", 32'(rvalid2), 32'd0);
    chk("abort_rd", rd2, 32'd0);
    chk("abort_err", 32'(err2), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_resp", 32'(rvalid2), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    model_apply(1'b0, 4'h0, 32'h8, 32'h0, 1'b0, erd, eerr, eperr);
    acc2(1'b0, 4'h0, 32'h8, 32'h0, 1'b0, grd, gerr, gperr);
    chk("abort_word_kept", grd, 32'hDE22BE44);

    // Parity inject on lane 0, then read back.
    model_apply(1'b1, 4'h1, 32'hC, 32'h000000A7, 1'b1, erd, eerr, eperr);
    acc2(1'b1, 4'h1, 32'hC, 32'h000000A7, 1'b1, grd, gerr, gperr);
    model_apply(1'b0, 4'h0, 32'hC, 32'h0, 1'b0, erd, eerr, eperr);
    acc2(1'b0, 4'h0, 32'hC, 32'h0, 1'b0, grd, gerr, gperr);
    chk("pinj_rd", grd, ((32'hA5A50000 ^ (32'd3 * 32'h01010103)) & 32'hFFFFFF00) | 32'hA7);
`ifdef DMEM_PARITY_EN
    chk("pinj_perr", 32'(gperr), 32'd1);
`else
    chk("pinj_perr", 32'(gperr), 32'd0);
`endif

    // Randomized accesses against the model.
    for (int i = 0; i < 250; i++) begin
      logic        rw, rpi;
      logic [3:0]  rb;
      logic [31:0] rad, rdat;
      int unsigned sel;
      sel  = $urandom_range(0, 9);
      rw   = 1'($urandom);
      rb   = 4'($urandom);
      rdat = $urandom;
      rpi  = ($urandom_range(0, 3) == 0);
      if (sel < 8)       rad = 32'($urandom_range(0, 63)) << 2;
      else if (sel == 8) rad = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else               rad = $urandom | 32'h100;
      model_apply(rw, rb, rad, rdat, rpi, erd, eerr, eperr);
      acc2(rw, rb, rad, rdat, rpi, grd, gerr, gperr);
      chk($sformatf("rnd%0d_rd a=%h", i, rad), grd, erd);
      chk($sformatf("rnd%0d_err", i), 32'(gerr), 32'(eerr));
      chk($sformatf("rnd%0d_perr", i), 32'(gperr), 32'(eperr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
